// File: rtl/aes_dec_pkg.sv
// Shared widths, AES-128 constants and FSM encodings for the decryption key path.
package aes_dec_pkg;
  localparam int AES_KEY_W   = 128;
  localparam int AES_RCON_W  = 8;
  localparam int AES_ROUND_W = 4;

  localparam int                    AES128_NB_ROUNDS = 10;
  localparam logic [AES_RCON_W-1:0] AES128_RCON_LAST = 8'h36;

  localparam logic ST_IDLE_ENC = 1'b0;
  localparam logic ST_EMIT_ENC = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE_ENC,
    EMIT = ST_EMIT_ENC
  } state_t;
endpackage

// File: rtl/aes_inv_key_shedualing.sv
// Combinational inverse AES-128 key-schedule step: round key i and its rcon in,
// round key i-1 and the rcon for the following inverse step out.
module aes_inv_key_shedualing
  import aes_dec_pkg::*;
(
  input  logic [AES_KEY_W-1:0]  i_key,
  input  logic [AES_RCON_W-1:0] i_rcon,
  output logic [AES_KEY_W-1:0]  o_key,
  output logic [AES_RCON_W-1:0] o_rcon
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    r  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
    return (x << s) | (x >> (8 - s));
  endfunction

  // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;
  logic [31:0] w_rot;

  assign w_w0 = i_key[127:96];
  assign w_w1 = i_key[95:64];
  assign w_w2 = i_key[63:32];
  assign w_w3 = i_key[31:0];

  assign w_n3  = w_w3 ^ w_w2;
  assign w_n2  = w_w2 ^ w_w1;
  assign w_n1  = w_w1 ^ w_w0;
  assign w_rot = {w_n3[23:0], w_n3[31:24]};
  assign w_n0  = w_w0 ^ {sbox(w_rot[31:24]) ^ i_rcon, sbox(w_rot[23:16]),
                         sbox(w_rot[15:8]), sbox(w_rot[7:0])};

  assign o_key = {w_n0, w_n1, w_n2, w_n3};
  // Inverse xtime: odd values had the 0x1b reduction applied on the way up.
  assign o_rcon = i_rcon[0] ? {1'b1, 7'((i_rcon ^ 8'h1b) >> 1)} : (i_rcon >> 1);
endmodule

// File: rtl/aes_dec_key_sched_ctrl.sv
// Decryption key sequencer: accepts the round-10 key and emits round keys 10..0.
// Optional replay of the last key via restart_i when AES_DEC_KEY_RESTART_EN is defined.
module aes_dec_key_sched_ctrl
  import aes_dec_pkg::*;
#(
  parameter int                    NB_ROUNDS = AES128_NB_ROUNDS,
  parameter logic [AES_RCON_W-1:0] RCON_INIT = AES128_RCON_LAST
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_v_i,
  input  logic [AES_KEY_W-1:0]   key_i,
  output logic                   key_ready_o,
`ifdef AES_DEC_KEY_RESTART_EN
  input  logic                   restart_i,
`endif
  output logic                   rkey_v_o,
  output logic [AES_KEY_W-1:0]   rkey_o,
  output logic [AES_ROUND_W-1:0] rkey_round_o,
  input  logic                   rkey_ready_i,
  output logic                   busy_o
);
  state_t                 r_state;
  logic [AES_KEY_W-1:0]   r_key;
  logic [AES_RCON_W-1:0]  r_rcon;
  logic [AES_ROUND_W-1:0] r_round;
  logic [AES_KEY_W-1:0]   w_key_next;
  logic [AES_RCON_W-1:0]  w_rcon_next;
  logic                   w_accept;
  logic                   w_fire;

  aes_inv_key_shedualing u_inv_ks (
    .i_key  (r_key),
    .i_rcon (r_rcon),
    .o_key  (w_key_next),
    .o_rcon (w_rcon_next)
  );

  assign w_accept = key_v_i & (r_state == IDLE);
  assign w_fire   = (r_state == EMIT) & rkey_ready_i;

`ifdef AES_DEC_KEY_RESTART_EN
  logic [AES_KEY_W-1:0] r_base;
  logic                 r_base_v;
  logic                 w_restart;

  assign w_restart = (r_state == IDLE) & restart_i & r_base_v & ~key_v_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base   <= '0;
      r_base_v <= 1'b0;
    end else if (w_accept) begin
      r_base   <= key_i;
      r_base_v <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_rcon  <= RCON_INIT;
      r_round <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_key   <= key_i;
            r_rcon  <= RCON_INIT;
            r_round <= AES_ROUND_W'(NB_ROUNDS);
            r_state <= EMIT;
          end
`ifdef AES_DEC_KEY_RESTART_EN
          else if (w_restart) begin
            r_key   <= r_base;
            r_rcon  <= RCON_INIT;
            r_round <= AES_ROUND_W'(NB_ROUNDS);
            r_state <= EMIT;
          end
`endif
        end
        EMIT: begin
          // Round 0 leaves the registers untouched so the counter never wraps.
          if (w_fire) begin
            if (r_round != '0) begin
              r_key   <= w_key_next;
              r_rcon  <= w_rcon_next;
              r_round <= r_round - 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign key_ready_o  = (r_state == IDLE);
  assign rkey_v_o     = (r_state == EMIT);
  assign busy_o       = (r_state != IDLE);
  assign rkey_o       = r_key;
  assign rkey_round_o = r_round;
endmodule

// File: tb/tb_aes_dec_key_sched_ctrl.sv
// Scoreboard bench: forward AES-128 key expansion model predicts round keys 10..0.
// Restart scenarios are exercised when AES_DEC_KEY_RESTART_EN is defined.
module tb_aes_dec_key_sched_ctrl;
  logic         clk = 1'b0;
  logic         reset;
  logic         key_v_i;
  logic [127:0] key_i;
  logic         key_ready_o;
  logic         rkey_v_o;
  logic [127:0] rkey_o;
  logic [3:0]   rkey_round_o;
  logic         rkey_ready_i;
  logic         busy_o;
`ifdef AES_DEC_KEY_RESTART_EN
  logic         restart_i;
`endif

  aes_dec_key_sched_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .key_v_i      (key_v_i),
    .key_i        (key_i),
    .key_ready_o  (key_ready_o),
`ifdef AES_DEC_KEY_RESTART_EN
    .restart_i    (restart_i),
`endif
    .rkey_v_o     (rkey_v_o),
    .rkey_o       (rkey_o),
    .rkey_round_o (rkey_round_o),
    .rkey_ready_i (rkey_ready_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   round;
    logic [127:0] key;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  bit           rand_mode = 1'b0;
  logic [7:0]   sbox_t [0:255];
  logic [127:0] rk [0:10];
  logic [7:0]   rc_fwd [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [7:0]   rc_dec [0:9] = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rl(input logic [7:0] x, input int s);
    return (x << s) | (x >> (8 - s));
  endfunction

  // S-box table by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, qq, x;
    p = 8'h01; qq = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p  = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      qq = qq ^ {qq[6:0], 1'b0};
      qq = qq ^ {qq[5:0], 2'b0};
      qq = qq ^ {qq[3:0], 4'b0};
      if (qq[7]) qq = qq ^ 8'h09;
      x = qq ^ rl(qq, 1) ^ rl(qq, 2) ^ rl(qq, 3) ^ rl(qq, 4);
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]] ^ rc_fwd[i/4-1], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_sched();
    for (int r = 10; r >= 0; r--) q.push_back('{round: 4'(r), key: rk[r]});
  endtask

  task automatic send(input logic [127:0] k, input bit hold);
    bit done = 1'b0;
    key_i   = k;
    key_v_i = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (key_ready_o) begin
        chk("queue_empty_at_accept", 128'(q.size()), 128'd0);
        push_sched();
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL key_accept_timeout: got no acceptance expected acceptance");
      @(posedge clk); #1;
    end
    if (!hold) key_v_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !key_ready_o) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic set_mode(input bit m);
    rand_mode = m;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rkey_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      rkey_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pop on every handshake, verify stability across stalls.
  bit           stall = 1'b0;
  logic [127:0] prev_key;
  logic [3:0]   prev_round;
  exp_t         e;
  always @(negedge clk) begin
    if (reset) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("stall_valid", 128'(rkey_v_o), 128'd1);
        chk("stall_key", rkey_o, prev_key);
        chk("stall_round", 128'(rkey_round_o), 128'(prev_round));
      end
      if (rkey_v_o && rkey_ready_i) begin
        stall = 1'b0;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rkey: got round %0d key %h expected none", rkey_round_o, rkey_o);
        end else begin
          e = q.pop_front();
          chk("rkey_round", 128'(rkey_round_o), 128'(e.round));
          chk("rkey", rkey_o, e.key);
          if (e.round >= 1 && e.round <= 10)
            chk("rcon", 128'(dut.r_rcon), 128'(rc_dec[10 - e.round]));
        end
      end else if (rkey_v_o) begin
        stall      = 1'b1;
        prev_key   = rkey_o;
        prev_round = rkey_round_o;
      end else begin
        stall = 1'b0;
      end
    end
  end

  initial begin
    logic [127:0] ka, kb;
    bit           seen;
    build_sbox();
    reset = 1'b1; key_v_i = 1'b0; key_i = '0;
`ifdef AES_DEC_KEY_RESTART_EN
    restart_i = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_key_ready", 128'(key_ready_o), 128'd1);
    chk("rst_rkey_v", 128'(rkey_v_o), 128'd0);
    chk("rst_rkey", rkey_o, 128'd0);
    chk("rst_round", 128'(rkey_round_o), 128'd0);
    chk("rst_busy", 128'(busy_o), 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

`ifdef AES_DEC_KEY_RESTART_EN
    restart_i = 1'b1;
    @(posedge clk); #1;
    restart_i = 1'b0;
    @(negedge clk);
    chk("restart_no_base_v", 128'(rkey_v_o), 128'd0);
    chk("restart_no_base_busy", 128'(busy_o), 128'd0);
    @(posedge clk); #1;
`endif

    // FIPS-197 vector with an always-ready sink and exact timing.
    set_mode(1'b0);
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    send(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      chk($sformatf("fips_valid_c%0d", j), 128'(rkey_v_o), (j <= 11) ? 128'd1 : 128'd0);
      chk($sformatf("fips_ready_c%0d", j), 128'(key_ready_o), (j <= 11) ? 128'd0 : 128'd1);
    end
    drain();

`ifdef AES_DEC_KEY_RESTART_EN
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    seen = 1'b0;
    restart_i = 1'b1;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (key_ready_o) begin
        push_sched();
        seen = 1'b1;
      end
      @(posedge clk); #1;
    end
    restart_i = 1'b0;
    drain();
`endif

    // Random keys under random backpressure.
    set_mode(1'b1);
    for (int t = 0; t < 4; t++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      expand(ka);
      send(rk[10], 1'b0);
      drain();
    end

    // key_v_i held through EMIT: second key waits for IDLE.
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    expand(ka);
    send(rk[10], 1'b1);
    expand(kb);
    send(rk[10], 1'b0);
    drain();

    // Reset in the middle of a schedule.
    set_mode(1'b0);
    ka = {$urandom, $urandom, $urandom, $urandom};
    expand(ka);
    send(rk[10], 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (rkey_v_o && rkey_round_o == 4'd5) seen = 1'b1;
    end
    chk("reached_round5", 128'(seen), 128'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_key_ready", 128'(key_ready_o), 128'd1);
    chk("midrst_rkey_v", 128'(rkey_v_o), 128'd0);
    chk("midrst_rkey", rkey_o, 128'd0);
    chk("midrst_round", 128'(rkey_round_o), 128'd0);
    chk("midrst_busy", 128'(busy_o), 128'd0);
    q.delete();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle", 128'(rkey_v_o), 128'd0);
    @(posedge clk); #1;
    kb = {$urandom, $urandom, $urandom, $urandom};
    expand(kb);
    send(rk[10], 1'b0);
    drain();

`ifdef AES_DEC_KEY_RESTART_EN
    // restart_i together with key_v_i: the new key wins, then replay it.
    ka = {$urandom, $urandom, $urandom, $urandom};
    expand(ka);
    restart_i = 1'b1;
    send(rk[10], 1'b0);
    restart_i = 1'b0;
    drain();
    seen = 1'b0;
    restart_i = 1'b1;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (key_ready_o) begin
        push_sched();
        seen = 1'b1;
      end
      @(posedge clk); #1;
    end
    restart_i = 1'b0;
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
